// File: rtl/usb_audio_pkg.sv
// Shared FSM state type and width helpers for the USB audio PCM FIFO.
package usb_audio_pkg;

  typedef enum logic {
    StFill = 1'b0,
    StPlay = 1'b1
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned sample_bytes);
    return channels * sample_bytes * 8;
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/usb_audio_pcm_fifo_if.sv
// Byte-stream input and PCM frame output bundle of the USB audio PCM FIFO.
// master drives the byte stream; slave is the FIFO itself.
interface usb_audio_pcm_fifo_if #(
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned LEVEL_W = 8
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_sop;
  logic [FRAME_W-1:0] audio_data;
  logic               audio_valid;
  logic               underrun;
  logic               overrun;
  logic [LEVEL_W-1:0] level;

  modport master (
    output in_data, in_valid, in_sop,
    input  audio_data, audio_valid, underrun, overrun, level
  );

  modport slave (
    input  in_data, in_valid, in_sop,
    output audio_data, audio_valid, underrun, overrun, level
  );
endinterface

// File: rtl/usb_audio_frame_assembler.sv
// Packs little-endian bytes into one PCM frame; commit_o pulses the cycle after the last byte.
module usb_audio_frame_assembler import usb_audio_pkg::*; #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_BYTES = 2,
  localparam int unsigned FrameW      = frame_bits(CHANNELS, SAMPLE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  input  logic              in_sop_i,
  output logic [FrameW-1:0] frame_o,
  output logic              commit_o
);
  localparam int unsigned NBytes = CHANNELS * SAMPLE_BYTES;
  localparam int unsigned CntW   = $clog2(NBytes);
  localparam logic [CntW-1:0] LastPos = CntW'(NBytes - 1);

  logic [CntW-1:0]   cnt_q, cnt_d, pos;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              commit_q, commit_d;

  always_comb begin
    // A start-of-packet byte always lands in slot 0, dropping any partial frame.
    pos      = in_sop_i ? '0 : cnt_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    commit_d = 1'b0;
    if (in_valid_i) begin
      frame_d[pos*8 +: 8] = in_data_i;
      if (pos == LastPos) begin
        cnt_d    = '0;
        commit_d = 1'b1;
      end else begin
        cnt_d = pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      frame_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      commit_q <= commit_d;
    end
  end

  assign frame_o  = frame_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/usb_audio_pcm_fifo.sv
// Frame ring buffer with prefill, underrun/overrun handling and fractional-rate playback.
// Define USB_AUDIO_PCM_UNSIGNED_EN for offset-binary output (sample MSBs inverted).
module usb_audio_pcm_fifo import usb_audio_pkg::*; #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_BYTES = 2,
  parameter int unsigned DEPTH        = 192,
  parameter int unsigned PREFILL      = 96,
  parameter int unsigned CLK_HZ       = 60_000_000,
  parameter int unsigned FS_HZ        = 48_000
) (
  input logic                clk,
  input logic                rst,
  usb_audio_pcm_fifo_if.slave io
);
  localparam int unsigned FrameW = frame_bits(CHANNELS, SAMPLE_BYTES);
  localparam int unsigned PtrW   = ptr_bits(DEPTH);
  localparam int unsigned LevelW = level_bits(DEPTH);
  localparam int unsigned AccW   = $clog2(CLK_HZ) + 1;

  localparam logic [AccW-1:0]   FsInc    = AccW'(FS_HZ);
  localparam logic [AccW-1:0]   ClkMod   = AccW'(CLK_HZ);
  localparam logic [LevelW-1:0] LevelMax = LevelW'(DEPTH);
  localparam logic [LevelW-1:0] LevelPre = LevelW'(PREFILL);
  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(DEPTH - 1);

`ifdef USB_AUDIO_PCM_UNSIGNED_EN
  function automatic logic [FrameW-1:0] msb_mask();
    logic [FrameW-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) m[(c+1)*SAMPLE_BYTES*8-1] = 1'b1;
    return m;
  endfunction
  localparam logic [FrameW-1:0] OutMask = msb_mask();
`else
  localparam logic [FrameW-1:0] OutMask = '0;
`endif

  logic [FrameW-1:0] frame;
  logic              commit;
  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d, acc_sum;
  logic              tick, pop, empty_tick, accept, drop;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              valid_q, valid_d, under_q, under_d, over_q, over_d, mute_q, mute_d;
  logic [FrameW-1:0] mem_q [DEPTH];
  logic [FrameW-1:0] rd_data_q;

  usb_audio_frame_assembler #(
    .CHANNELS     (CHANNELS),
    .SAMPLE_BYTES (SAMPLE_BYTES)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (io.in_data),
    .in_valid_i (io.in_valid),
    .in_sop_i   (io.in_sop),
    .frame_o    (frame),
    .commit_o   (commit)
  );

  always_comb begin
    acc_sum    = acc_q + FsInc;
    tick       = (acc_sum >= ClkMod);
    acc_d      = tick ? (acc_sum - ClkMod) : acc_sum;
    state_d    = state_q;
    pop        = 1'b0;
    empty_tick = 1'b0;
    unique case (state_q)
      StFill: if (level_q >= LevelPre) state_d = StPlay;
      StPlay: begin
        if (tick) begin
          if (level_q == '0) begin
            empty_tick = 1'b1;
            state_d    = StFill;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase

    // A same-cycle pop frees the slot, so a full buffer still accepts the frame.
    accept   = commit && ((level_q != LevelMax) || pop);
    drop     = commit && !accept;
    wr_ptr_d = accept ? ((wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? ((rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    level_d  = level_q;
    if (accept && !pop)      level_d = level_q + 1'b1;
    else if (pop && !accept) level_d = level_q - 1'b1;

    valid_d = pop || empty_tick;
    under_d = empty_tick;
    over_d  = drop;
    mute_d  = pop ? 1'b0 : (empty_tick ? 1'b1 : mute_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      mute_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
      over_q   <= over_d;
      mute_q   <= mute_d;
    end
  end

  // Storage kept reset-free with a registered read port so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= frame;
    if (pop)    rd_data_q <= mem_q[rd_ptr_q];
  end

  assign io.audio_data  = (mute_q ? '0 : rd_data_q) ^ OutMask;
  assign io.audio_valid = valid_q;
  assign io.underrun    = under_q;
  assign io.overrun     = over_q;
  assign io.level       = level_q;

endmodule
